tx_arbiter: RTL and testbench
=============================

// Module: tx_arbiter
// PURPOSE
//  Shares the single TX unit among NUM_REQ router-core requesters (token/data queues).
//  Grants the TX unit round-robin, one packet of PKT_BYTES bytes per grant.
//  Sequences each byte through the TX handshake (TX_Data_Valid / TX_Data_Ready) and pops the
//  winner's queue per byte. Sits between the requester queues and the TX serializer.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  DATA_W     8    byte width on the TX data path
//  PKT_BYTES  4    bytes per granted packet (1..255)
//  TIMEOUT    255  max cycles in SEND waiting for TX_Data_Ready to fall (1..255)
// PORTS
//  clk            in   1                 system clock, rising edge
//  rst            in   1                 asynchronous reset, active-high
//  req            in   NUM_REQ           req[i]=1: requester i has a byte at req_data slice i
//  req_data       in   NUM_REQ*DATA_W    byte of requester i at [i*DATA_W +: DATA_W]
//  grant          out  NUM_REQ           one-hot owner of the TX unit; 0 when idle
//  byte_ack       out  NUM_REQ           1-cycle pulse: requester i's byte taken, pop it
//  pkt_abort      out  1                 1-cycle pulse: owner dropped req mid-packet
//  tx_timeout     out  1                 sticky: TX unit failed to take a byte; cleared only by rst
//  TX_Data        out  DATA_W            registered byte to TX unit
//  TX_Data_Valid  out  1                 byte on TX_Data is valid
//  TX_Data_Ready  in   1                 TX unit idle and able to accept; falls when tx starts
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, grant=0, byte_ack=0, pkt_abort=0, tx_timeout=0,
//   TX_Data=0, TX_Data_Valid=0, rr_ptr=0, byte_cnt=0. Reset mid-packet drops it; no abort pulse.
//  States (Moore outputs except byte_ack/pkt_abort, which are registered pulses):
//   IDLE : grant=0, Valid=0. If |req && TX_Data_Ready -> LOAD; winner = first set req[i]
//          scanning i=rr_ptr, rr_ptr+1, ... mod NUM_REQ. grant registered on that edge.
//   LOAD : grant held. If req[owner]: TX_Data<=req_data[owner], byte_ack[owner] pulses, -> SEND.
//          If !req[owner]: pkt_abort pulses, rr_ptr<=owner+1, -> IDLE (grant clears next cycle).
//   SEND : Valid=1, data held stable. TX_Data_Ready=0 -> DRAIN. Wait counter increments each
//          cycle; reaching TIMEOUT: tx_timeout<=1, Valid dropped, rr_ptr<=owner+1, -> IDLE.
//   DRAIN: Valid=0. Wait for TX_Data_Ready=1. Then if byte_cnt==PKT_BYTES-1: byte_cnt<=0,
//          rr_ptr<=owner+1 (mod NUM_REQ), -> IDLE; else byte_cnt++, -> LOAD.
//  Latency: req seen in IDLE with Ready=1 -> grant at +1, byte_ack and TX_Data at +2, Valid at +2.
//  Per byte: exactly one byte_ack, asserted same edge TX_Data is loaded; never in any other state.
//  Grant is never re-arbitrated mid-packet; other req ignored until owner returns to IDLE.
//  Simultaneous: req[owner] falling in the same cycle as LOAD -> abort (req sampled in LOAD only).
//  TX_Data_Ready low in IDLE blocks arbitration regardless of req.
//  rr_ptr wraps NUM_REQ-1 -> 0; single requester may win back-to-back packets.
//  byte_cnt width = $clog2(PKT_BYTES+1); wait counter 8 bits, saturates, resets on entry to SEND.
//  tx_timeout does not block further operation.
//  Unused/illegal state encodings -> IDLE on next edge, outputs as IDLE.
// STRUCTURE
//  Package tx_arb_pkg: state encodings (IDLE, LOAD, SEND, DRAIN), default parameter constants.
//  Sub-module rr_arbiter: combinational round-robin pick (req, rr_ptr -> one-hot winner, any).
//  Top holds FSM, rr_ptr, byte_cnt, wait counter, data/ack registers, output mux.
// TESTING
//  Reset mid-SEND, rst=1 -> next cycle all outputs 0, state IDLE, later req=4'b0001 re-granted.
//  req=4'b0110, rr_ptr=0, TX model (Ready falls 1 cyc after Valid, rises 10 cyc later), PKT_BYTES=4
//   -> grant=0010 for 4 bytes, 4 byte_ack[1] pulses, then grant=0100.
//  req=4'b1111 held, 3 packets -> grants 0001,0010,0100 in order; each 4 bytes, no overlap.
//  Owner req drops after 2nd byte_ack -> pkt_abort pulse in LOAD, grant=0, rr_ptr=owner+1.
//  TX model never drops Ready, TIMEOUT=8 -> Valid for 8 cycles, tx_timeout=1 sticky, state IDLE.
//  Ready held low in IDLE with req=4'b0001 -> no grant; Ready rises -> grant=0001 next edge.

Source files
------------

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the TX arbiter: FSM state encodings and default sizing.
package tx_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PKT_BYTES = 4;
  localparam int DEF_TIMEOUT   = 255;
  localparam int WAIT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester queues and TX serializer handshake as seen by the arbiter.
// The master modport is the arbiter side; slave is the requester/TX side.
interface tx_arbiter_if #(
  parameter int NUM_REQ = tx_arb_pkg::DEF_NUM_REQ,
  parameter int DATA_W  = tx_arb_pkg::DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        byte_ack;
  logic                      pkt_abort;
  logic                      tx_timeout;
  logic [DATA_W-1:0]         TX_Data;
  logic                      TX_Data_Valid;
  logic                      TX_Data_Ready;

  modport master (
    input  req, req_data, TX_Data_Ready,
    output grant, byte_ack, pkt_abort, tx_timeout, TX_Data, TX_Data_Valid
  );

  modport slave (
    output req, req_data, TX_Data_Ready,
    input  grant, byte_ack, pkt_abort, tx_timeout, TX_Data, TX_Data_Valid
  );
endinterface

// File: rtl/tx_arbiter_rr.sv
// Combinational round-robin pick: first set request scanning upward from ptr_i,
// wrapping at NUM_REQ. Returns the one-hot winner, its index and whether any won.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin : pick
    logic [PTR_W:0] pos;
    // NOTE: every output gets a default before the loop, so no path infers a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      if (!any_o && req_i[pos[PTR_W-1:0]]) begin
        any_o                   = 1'b1;
        idx_o                   = pos[PTR_W-1:0];
        grant_o[pos[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin owner of the single TX unit: one PKT_BYTES packet per grant,
// each byte sequenced through the TX_Data_Valid / TX_Data_Ready handshake.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PKT_BYTES = DEF_PKT_BYTES,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  tx_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PKT_BYTES + 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  byte_ack_q, byte_ack_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                pkt_abort_q, pkt_abort_d;
  logic                tx_timeout_q, tx_timeout_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [PTR_W-1:0]    next_ptr;
  logic [DATA_W-1:0]   owner_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == PTR_W'(k)) owner_data = bus.req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    wait_d       = wait_q;
    tx_data_d    = tx_data_q;
    byte_ack_d   = '0;
    pkt_abort_d  = 1'b0;
    tx_timeout_d = tx_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_any && bus.TX_Data_Ready) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // req is sampled only here; a drop at any other time surfaces as an abort on the next LOAD
        if (bus.req[owner_q]) begin
          tx_data_d  = owner_data;
          byte_ack_d = grant_q;
          wait_d     = '0;
          state_d    = ST_SEND;
        end else begin
          pkt_abort_d = 1'b1;
          rr_ptr_d    = next_ptr;
          byte_cnt_d  = '0;
          grant_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!bus.TX_Data_Ready) begin
          state_d = ST_DRAIN;
        end else if (wait_q >= WAIT_W'(TIMEOUT - 1)) begin
          tx_timeout_d = 1'b1;
          rr_ptr_d     = next_ptr;
          byte_cnt_d   = '0;
          grant_d      = '0;
          state_d      = ST_IDLE;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.TX_Data_Ready) begin
          if (byte_cnt_q == CNT_W'(PKT_BYTES - 1)) begin
            byte_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            grant_d    = '0;
            state_d    = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = ST_LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      byte_ack_q   <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      wait_q       <= '0;
      tx_data_q    <= '0;
      pkt_abort_q  <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      byte_ack_q   <= byte_ack_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      wait_q       <= wait_d;
      tx_data_q    <= tx_data_d;
      pkt_abort_q  <= pkt_abort_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.byte_ack      = byte_ack_q;
  assign bus.pkt_abort     = pkt_abort_q;
  assign bus.tx_timeout    = tx_timeout_q;
  assign bus.TX_Data       = tx_data_q;
  assign bus.TX_Data_Valid = (state_q == ST_SEND);

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: requester queues and a TX unit model drive the DUT,
// a scoreboard holds expected (owner, byte) pairs popped on every byte_ack.
module tb_tx_arbiter;
  import tx_arb_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int PKT_BYTES = 4;
  localparam int TIMEOUT   = 8;

  typedef enum int {TX_AUTO, TX_HIGH, TX_LOW} tx_mode_e;
  typedef struct packed {
    logic [NUM_REQ-1:0] ack;
    logic [DATA_W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PKT_BYTES(PKT_BYTES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tx_mode_e                  tx_mode    = TX_AUTO;
  logic                      ready_r    = 1'b1;
  int                        ready_cnt  = 0;
  logic [NUM_REQ-1:0]        req_r      = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data_r = '0;
  int                        given   [NUM_REQ] = '{default: 0};
  int                        taken   [NUM_REQ] = '{default: 0};
  int                        exp_cnt [NUM_REQ] = '{default: 0};
  exp_t                      sb[$];
  int                        checks = 0;
  int                        errors = 0;

  assign bus.req           = req_r;
  assign bus.req_data      = req_data_r;
  assign bus.TX_Data_Ready = ready_r;

  function automatic logic [DATA_W-1:0] byte_of(int who, int seq);
    logic [3:0] hi, lo;
    hi = 4'(who);
    lo = 4'(seq);
    return {hi, lo};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester queues, TX unit model and scoreboard, all evaluated on the falling edge.
  always @(negedge clk) begin : model
    exp_t e;
    if (|bus.byte_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_byte_ack", 32'(bus.byte_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("byte_ack_owner", 32'(bus.byte_ack), 32'(e.ack));
        check("tx_data", 32'(bus.TX_Data), 32'(e.data));
        check("grant_matches_ack", 32'(bus.grant), 32'(e.ack));
        check("valid_with_ack", 32'(bus.TX_Data_Valid), 32'd1);
      end
      for (int i = 0; i < NUM_REQ; i++) if (bus.byte_ack[i]) taken[i]++;
    end
    if (bus.pkt_abort) check("grant_clear_on_abort", 32'(bus.grant), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_r[i]                        = (given[i] > taken[i]);
      req_data_r[i*DATA_W +: DATA_W]  = byte_of(i, taken[i]);
    end
    case (tx_mode)
      TX_HIGH: ready_r = 1'b1;
      TX_LOW: begin
        ready_r   = 1'b0;
        ready_cnt = 0;
      end
      default: begin
        if (ready_r && bus.TX_Data_Valid) begin
          ready_r   = 1'b0;
          ready_cnt = 10;
        end else if (!ready_r) begin
          if (ready_cnt <= 1) ready_r = 1'b1;
          else ready_cnt--;
        end
      end
    endcase
  end

  task automatic give(int who, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ack  = NUM_REQ'(1) << who;
      e.data = byte_of(who, exp_cnt[who]);
      exp_cnt[who]++;
      sb.push_back(e);
    end
    given[who] += n;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string tag, int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.grant == '0 && !bus.TX_Data_Valid) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_grant"},      32'(bus.grant),         32'd0);
    check({tag, "_byte_ack"},   32'(bus.byte_ack),      32'd0);
    check({tag, "_pkt_abort"},  32'(bus.pkt_abort),     32'd0);
    check({tag, "_tx_timeout"}, 32'(bus.tx_timeout),    32'd0);
    check({tag, "_tx_data"},    32'(bus.TX_Data),       32'd0);
    check({tag, "_valid"},      32'(bus.TX_Data_Valid), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not reach its summary within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit seen;
    int vcnt;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    drive_edge();
    rst = 1'b0;

    // Ready low in IDLE blocks arbitration; its rise grants on the next edge.
    tx_mode = TX_LOW;
    @(negedge clk);
    drive_edge();
    give(0, 4);
    repeat (5) @(negedge clk);
    check("no_grant_ready_low", 32'(bus.grant), 32'd0);
    drive_edge();
    tx_mode = TX_AUTO;
    @(negedge clk);
    check("no_grant_before_ready_edge", 32'(bus.grant), 32'd0);
    @(negedge clk);
    check("grant_latency", 32'(bus.grant), 32'b0001);
    check("valid_low_in_load", 32'(bus.TX_Data_Valid), 32'd0);
    @(negedge clk);
    check("valid_latency", 32'(bus.TX_Data_Valid), 32'd1);
    wait_idle("pkt_req0_done", 300);

    // rr_ptr=1: requesters 1 and 2 served in order, 4 bytes each.
    drive_edge();
    give(1, 4);
    give(2, 4);
    wait_idle("rr_0110_done", 500);

    // rr_ptr=3: owner 3 has only 2 bytes -> abort in LOAD, rr_ptr wraps to 0.
    drive_edge();
    give(3, 2);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.pkt_abort) seen = 1'b1;
    end
    check("abort_seen", 32'(seen), 32'd1);
    check("valid_low_on_abort", 32'(bus.TX_Data_Valid), 32'd0);
    check("sb_empty_on_abort", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("abort_one_cycle", 32'(bus.pkt_abort), 32'd0);

    // rr_ptr=0 after wrap: requester 0 first, then 3.
    drive_edge();
    give(0, 4);
    give(3, 4);
    wait_idle("wrap_order_done", 500);

    // All four requesting: grants 0001, 0010, 0100, 1000 in order.
    drive_edge();
    for (int i = 0; i < NUM_REQ; i++) give(i, 4);
    wait_idle("all_four_done", 1000);

    // Single requester wins back-to-back packets.
    drive_edge();
    give(0, 8);
    wait_idle("back_to_back_done", 500);

    // TX never drops Ready: Valid for TIMEOUT cycles, then sticky tx_timeout.
    drive_edge();
    tx_mode = TX_HIGH;
    give(1, 1);
    seen = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.tx_timeout) seen = 1'b1;
      else if (bus.TX_Data_Valid) vcnt++;
    end
    check("timeout_seen", 32'(seen), 32'd1);
    check("timeout_valid_cycles", 32'(vcnt), 32'(TIMEOUT));
    check("timeout_grant_idle", 32'(bus.grant), 32'd0);
    check("timeout_valid_low", 32'(bus.TX_Data_Valid), 32'd0);
    repeat (4) @(negedge clk);
    check("timeout_sticky", 32'(bus.tx_timeout), 32'd1);

    // Operation continues after a timeout; rr_ptr moved to 2.
    drive_edge();
    tx_mode = TX_AUTO;
    give(2, 4);
    wait_idle("after_timeout_done", 300);
    check("timeout_still_sticky", 32'(bus.tx_timeout), 32'd1);

    // Reset in the middle of SEND drops the packet and clears everything.
    drive_edge();
    tx_mode = TX_HIGH;
    give(3, 4);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.TX_Data_Valid) seen = 1'b1;
    end
    check("send_reached_before_reset", 32'(seen), 32'd1);
    drive_edge();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_send_reset");
    sb.delete();
    given[3] = taken[3];
    tx_mode  = TX_AUTO;
    repeat (2) @(negedge clk);
    drive_edge();
    rst = 1'b0;
    give(0, 4);
    wait_idle("regrant_after_reset", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
